// File: rtl/quad_encoder_counter.sv
// ---------------------------------------------------------------------------
// quad_encoder_counter
//
// Turns a pair of quadrature encoder channels into a signed 32-bit position
// count. Both channels are synchronized, then debounced by a per-channel run
// filter, then the filtered {A,B} state is decoded against the previous one.
//
// Parameters
//   FILTER_LEN : consecutive disagreeing cycles before a filtered channel
//                follows its synchronized input (1..255)
//   COUNT_MODE : 4 = count every legal edge, 1 = one count per full cycle
//   INVERT     : 1 = negate every count step and the reported direction
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   enc_a   : encoder channel A (asynchronous to clk)
//   enc_b   : encoder channel B (asynchronous to clk)
//   clr     : synchronous clear of rot_cnt, enc_err and err_cnt
//   rot_cnt : signed cumulative position, wraps modulo 2^32
//   dir     : direction of the last counted step (1 forward, 0 reverse)
//   enc_err : sticky flag, set when both filtered channels change together
//   err_cnt : saturating count of such illegal transitions
// ---------------------------------------------------------------------------
module quad_encoder_counter #(
  parameter int FILTER_LEN = 4,
  parameter int COUNT_MODE = 4,
  parameter int INVERT     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        clr,
  output logic [31:0] rot_cnt,
  output logic        dir,
  output logic        enc_err,
  output logic [15:0] err_cnt
);

  // The run counter holds "disagreeing cycles seen so far"; the channel flips
  // on the cycle that would make the run reach FILTER_LEN.
  localparam logic [7:0] RUN_LAST = 8'(FILTER_LEN - 1);

  // Bit 1 is channel A, bit 0 is channel B throughout.
  logic [1:0] meta;
  logic [1:0] sync;
  logic [1:0] filt;
  logic [1:0] prev;
  logic [7:0] run_len [2];

  logic fwd;
  logic rev;
  logic dbl;
  logic step_up;
  logic step_dn;

  // Two-flop synchronizer for both channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 2'b00;
      sync <= 2'b00;
    end else begin
      meta <= {enc_a, enc_b};
      sync <= meta;
    end
  end

  // Independent run filter per channel: any agreeing cycle restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt       <= 2'b00;
      run_len[0] <= 8'd0;
      run_len[1] <= 8'd0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync[ch] != filt[ch]) begin
          if (run_len[ch] == RUN_LAST) begin
            filt[ch]    <= sync[ch];
            run_len[ch] <= 8'd0;
          end else begin
            run_len[ch] <= run_len[ch] + 8'd1;
          end
        end else begin
          run_len[ch] <= 8'd0;
        end
      end
    end
  end

  // Transition decode: forward order is 00 -> 10 -> 11 -> 01 -> 00.
  always_comb begin
    fwd     = 1'b0;
    rev     = 1'b0;
    dbl     = 1'b0;
    step_up = 1'b0;
    step_dn = 1'b0;
    case ({prev, filt})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: dbl = 1'b1;
      default: ;
    endcase
    // In x1 mode only the step that lands on 00 counts.
    if (COUNT_MODE == 1) begin
      step_up = fwd && (filt == 2'b00);
      step_dn = rev && (filt == 2'b00);
    end else begin
      step_up = fwd;
      step_dn = rev;
    end
    if (INVERT != 0) begin
      {step_up, step_dn} = {step_dn, step_up};
    end
  end

  // Output registers. prev keeps tracking filt through clr so a clear never
  // produces a false step afterwards; clr itself overrides any same-cycle
  // count or error event, and dir keeps its value in that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 2'b00;
      rot_cnt <= 32'd0;
      dir     <= 1'b0;
      enc_err <= 1'b0;
      err_cnt <= 16'd0;
    end else begin
      prev <= filt;
      if (clr) begin
        rot_cnt <= 32'd0;
        enc_err <= 1'b0;
        err_cnt <= 16'd0;
      end else begin
        if (step_up) begin
          rot_cnt <= rot_cnt + 32'd1;
          dir     <= 1'b1;
        end else if (step_dn) begin
          rot_cnt <= rot_cnt - 32'd1;
          dir     <= 1'b0;
        end
        if (dbl) begin
          enc_err <= 1'b1;
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/quad_encoder_counter.md
QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive stable cycles required before a filtered channel changes; legal range 1..255.
REQ-002 SHALL have parameter COUNT_MODE, default 4: 4 counts every legal edge, 1 counts one edge per quadrature cycle.
REQ-003 SHALL have parameter INVERT, default 0: 1 negates every count step.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 enc_a  input  1  encoder channel A, asynchronous to clk.
REQ-007 enc_b  input  1  encoder channel B, asynchronous to clk.
REQ-008 clr  input  1  synchronous clear of count and error state.
REQ-009 rot_cnt  output  32  signed cumulative position count; feeds the speed controller, which differences successive samples.
REQ-010 dir  output  1  direction of last count event: 1 forward, 0 reverse.
REQ-011 enc_err  output  1  sticky illegal-transition flag.
REQ-012 err_cnt  output  16  illegal-transition counter, saturating.

Function
REQ-013 SHALL pass each channel through a 2-flop synchronizer before any other use.
REQ-014 SHALL filter each channel independently: filtered value takes synchronized value only after it differs from filtered value on FILTER_LEN consecutive edges; any agreeing cycle restarts the run.
REQ-015 SHALL register previous filtered state {A,B} and decode current against it every cycle.
REQ-016 Forward sequence SHALL be 00->10->11->01->00 (A leads B); reverse is the opposite order.
REQ-017 COUNT_MODE=4: each forward step +1, each reverse step -1.
REQ-018 COUNT_MODE=1: only 01->00 counts +1 and only 10->00 counts -1; other legal steps change nothing.
REQ-019 INVERT=1 SHALL negate the step sign and the dir value.
REQ-020 Both filtered bits changing in one cycle SHALL count nothing, set enc_err, and increment err_cnt, holding at 0xFFFF.
REQ-021 No change in the filtered state SHALL leave all outputs unchanged.
REQ-022 rot_cnt SHALL wrap modulo 2^32: 0x7FFFFFFF+1 gives 0x80000000; 0-1 gives 0xFFFFFFFF.
REQ-023 dir SHALL update only on a counted step and hold otherwise.
REQ-024 Latency: a level change first captured at edge N SHALL appear on rot_cnt after edge N+2+FILTER_LEN, which is 6 cycles at default.
REQ-025 clr SHALL zero rot_cnt, enc_err and err_cnt at the next edge; clr wins over a simultaneous count or error event.
REQ-026 clr SHALL NOT reset synchronizer, filter or previous-state registers, so no false step follows a clear.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst is high, all of the following SHALL be 0 immediately, without waiting for clk: synchronizers, filters, previous state, filter counters, rot_cnt, dir, enc_err and err_cnt.
REQ-029 After release, if filtered inputs settle at a non-00 state, that transition SHALL be decoded normally; a double change is flagged as an error.
REQ-030 rst asserted mid-count SHALL discard pending filter runs; counting resumes cleanly after release.

Verification
REQ-031 Reset mid-run: rot_cnt=25, assert rst between edges -> rot_cnt=0, dir=0, enc_err=0 before the next edge.
REQ-032 Default params, 10 forward quadrature cycles, 20 clk per phase -> rot_cnt=40, dir=1; then 3 reverse cycles -> rot_cnt=28, dir=0; first count edge lands 6 cycles after the input change.
REQ-033 Glitch: 3-cycle high pulse on enc_a with FILTER_LEN=4 -> rot_cnt unchanged, no error; repeat with a 4-cycle pulse -> rot_cnt +1, then -1.
REQ-034 Illegal: from state 00, toggle enc_a and enc_b on the same edge -> rot_cnt unchanged, enc_err=1, err_cnt=1; 65540 illegal events -> err_cnt=0xFFFF.
REQ-035 Wrap and x1: COUNT_MODE=1, from 0 one reverse cycle -> 0xFFFFFFFF; one forward cycle -> 0; 4 edges per cycle give only one count.
REQ-036 clr on the same edge as a counted step with rot_cnt=12 -> rot_cnt=0 and enc_err=0; the next legal step gives +/-1 exactly.
